tb_cheshire_boot_seq: RTL and testbench
=======================================

// Module: tb_cheshire_boot_seq
// PURPOSE
// Simulation-side boot sequencer downstream of the tb_cheshire_pkg config table. It holds the
// DUT in reset, hands off to the binary preloader in passive boot, then releases the core. It
// watches register writes for the end-of-computation (EOC) word and reports pass/fail/timeout.
// It sits between the testbench top and the DUT reset/boot pins.
// PARAMETERS
// CfgIdx         0             index into tb_cheshire_pkg::TbCheshireConfigs (0..NumCheshireConfigs-1)
// ResetCycles    16            cycles soc_rst_no is held low after start (>=1)
// TimeoutCycles  32'd1_000_000 RUN-state cycle budget; 0 disables timeout
// ExitAddr       32'h0300_0008 byte address of the EOC scratch register
// BootMode       2'd0          value driven on boot_mode_o; 0 = passive preload
// PORTS
// clk_i          in   1   clock
// rst_ni         in   1   asynchronous active-low reset
// start_i        in   1   one-cycle pulse; starts a sequence from IDLE only
// soc_rst_no     out  1   DUT reset, active-low
// boot_mode_o    out  2   DUT boot mode pins
// cfg_flags_o    out  3   {Ara, Clic, AxiRt} of the selected config; constant
// preload_req_o  out  1   request for the preloader to load the binary
// preload_done_i in   1   preloader finished
// exit_valid_i   in   1   observed register write valid
// exit_addr_i    in   32  write address
// exit_data_i    in   32  write data
// busy_o         out  1   sequence in progress (RST_HOLD/PRELOAD/RUN)
// done_o         out  1   sequence finished (sticky until next start_i)
// pass_o         out  1   done and exit code == 0
// timeout_o      out  1   done because the budget expired
// exit_code_o    out  31  exit_data_i[31:1] latched at EOC
// BEHAVIOUR
// - Reset: state IDLE; soc_rst_no=0; preload_req_o=0; busy/done/pass/timeout=0; exit_code_o=0;
//   counters=0. boot_mode_o=BootMode and cfg_flags_o are constant.
// - FSM: IDLE -> RST_HOLD -> (PRELOAD if BootMode==0) -> RUN -> DONE.
// - IDLE: soc_rst_no=0. start_i moves to RST_HOLD next cycle and clears done/pass/timeout/exit_code.
// - RST_HOLD: soc_rst_no=0 for exactly ResetCycles cycles (counter 0..ResetCycles-1).
//   The next state then drives soc_rst_no=1.
// - PRELOAD: preload_req_o=1 (registered) until the cycle preload_done_i is sampled high.
//   The state then goes to RUN and preload_req_o drops in the same transition.
//   A preload_done_i seen outside PRELOAD is ignored. PRELOAD has no timeout.
// - RUN: the cycle counter increments every cycle.
//   EOC = exit_valid_i && exit_addr_i==ExitAddr && exit_data_i[0].
//   On EOC: latch exit_code_o=exit_data_i[31:1], pass_o=(exit_data_i[31:1]==0), go to DONE.
//   Writes to ExitAddr with bit0=0 are ignored.
//   If TimeoutCycles!=0 and the counter reaches TimeoutCycles-1 without EOC: go to DONE with
//   timeout_o=1, pass_o=0.
//   If EOC and expiry happen in the same cycle, EOC wins.
// - DONE: done_o=1; soc_rst_no stays 1 (DUT is not reset again). start_i restarts at RST_HOLD.
// - start_i is ignored while busy_o=1.
// - Outputs change only on clk_i rising edges, except through rst_ni.
// - rst_ni asserted mid-sequence asynchronously forces the reset values and drives soc_rst_no=0
//   immediately.
// - CfgIdx >= NumCheshireConfigs is an elaboration error ($fatal in an initial block).
// - Counter width: $clog2 of max(ResetCycles, TimeoutCycles)+1, no wrap before the terminal value.
// TESTING
// - Default params, start_i pulse at cycle 5: soc_rst_no low through cycle 21, preload_req_o=1
//   from cycle 22.
// - Preload completes: preload_done_i at cycle 30 -> RUN. Write 0x0300_0008 data 0x1 -> done=1,
//   pass=1, exit_code=0.
// - EOC data 0x0000_0007 -> pass=0, exit_code=3. Same address with data 0x6 (bit0=0) -> no effect.
// - TimeoutCycles=100 with no EOC -> timeout_o=1, done_o=1 exactly 100 cycles after RUN entry.
//   EOC on cycle 100 -> pass, no timeout.
// - BootMode=1 -> PRELOAD skipped, preload_req_o never 1. CfgIdx=3 -> cfg_flags_o=3'b100.
// - rst_ni pulsed low during RUN: all outputs return to reset values asynchronously.
//   start_i during RST_HOLD is ignored.

Source files
------------

// File: rtl/tb_cheshire_boot_seq.sv
// rtl/tb_cheshire_boot_seq.sv - boot sequencer: DUT reset hold, passive preload handoff, EOC watch
module tb_cheshire_boot_seq #(
  parameter int unsigned CfgIdx        = 0,
  parameter int unsigned ResetCycles   = 16,
  parameter int unsigned TimeoutCycles = 32'd1_000_000,
  parameter logic [31:0] ExitAddr      = 32'h0300_0008,
  parameter logic [1:0]  BootMode      = 2'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        soc_rst_no,
  output logic [1:0]  boot_mode_o,
  output logic [2:0]  cfg_flags_o,
  output logic        preload_req_o,
  input  logic        preload_done_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_addr_i,
  input  logic [31:0] exit_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [30:0] exit_code_o
);

  // Mirror of the tb_cheshire_pkg config table, {Ara, Clic, AxiRt} per entry.
  localparam int unsigned NumCheshireConfigs = 4;
  localparam logic [NumCheshireConfigs-1:0][2:0] CfgTable = {3'b100, 3'b010, 3'b001, 3'b000};

  localparam int unsigned MaxCnt  = (ResetCycles > TimeoutCycles) ? ResetCycles : TimeoutCycles;
  localparam int unsigned CntW    = (MaxCnt < 1) ? 1 : $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] RstLast = CntW'(ResetCycles - 1);
  localparam logic [CntW-1:0] ToLast  = CntW'(TimeoutCycles - 1);
  localparam logic [1:0] CfgSel = 2'(CfgIdx);

  if (CfgIdx >= NumCheshireConfigs) begin : g_bad_cfg
    $fatal(1, "CfgIdx out of range of the config table");
  end

  typedef enum logic [2:0] {S_IDLE, S_RST_HOLD, S_PRELOAD, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [30:0]      code_q, code_d;
  logic             eoc, expired, restart;

  assign eoc     = exit_valid_i && (exit_addr_i == ExitAddr) && exit_data_i[0];
  assign expired = (TimeoutCycles != 0) && (cnt_q == ToLast);
  assign restart = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      code_q    <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_RST_HOLD;
          cnt_d   = '0;
        end
      end
      S_RST_HOLD: begin
        if (cnt_q == RstLast) begin
          state_d = (BootMode == 2'd0) ? S_PRELOAD : S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_PRELOAD: begin
        if (preload_done_i) state_d = S_RUN;
      end
      S_RUN: begin
        // Saturate so a disabled timeout never wraps the counter.
        if (eoc || expired) state_d = S_DONE;
        else if (cnt_q != '1) cnt_d = cnt_q + CntW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pass_d    = pass_q;
    timeout_d = timeout_q;
    code_d    = code_q;
    if (restart) begin
      pass_d    = 1'b0;
      timeout_d = 1'b0;
      code_d    = '0;
    end else if (state_q == S_RUN) begin
      // EOC takes priority over budget expiry in the same cycle.
      if (eoc) begin
        code_d    = exit_data_i[31:1];
        pass_d    = (exit_data_i[31:1] == 31'd0);
        timeout_d = 1'b0;
      end else if (expired) begin
        timeout_d = 1'b1;
        pass_d    = 1'b0;
      end
    end
    soc_rst_no    = (state_q == S_PRELOAD) || (state_q == S_RUN) || (state_q == S_DONE);
    preload_req_o = (state_q == S_PRELOAD);
    busy_o        = (state_q == S_RST_HOLD) || (state_q == S_PRELOAD) || (state_q == S_RUN);
    done_o        = (state_q == S_DONE);
    pass_o        = pass_q;
    timeout_o     = timeout_q;
    exit_code_o   = code_q;
    boot_mode_o   = BootMode;
    cfg_flags_o   = CfgTable[CfgSel];
  end

endmodule

// File: tb/tb_tb_cheshire_boot_seq.sv
// tb/tb_tb_cheshire_boot_seq.sv - scoreboard bench: default instance (A) and short-timeout/no-preload instance (B)
module tb_tb_cheshire_boot_seq;

  localparam logic [31:0] ExitAddr = 32'h0300_0008;

  typedef struct packed {
    logic        pass;
    logic        timeout;
    logic [30:0] code;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, start_a = 1'b0, pdone_a = 1'b0, ev_a = 1'b0;
  logic [31:0] ea_a = '0, ed_a = '0;
  logic        soc_a, preq_a, busy_a, done_a, pass_a, to_a;
  logic [1:0]  boot_a;
  logic [2:0]  cfg_a;
  logic [30:0] code_a;

  logic        rst_b = 1'b0, start_b = 1'b0, pdone_b = 1'b0, ev_b = 1'b0;
  logic [31:0] ea_b = '0, ed_b = '0;
  logic        soc_b, preq_b, busy_b, done_b, pass_b, to_b;
  logic [1:0]  boot_b;
  logic [2:0]  cfg_b;
  logic [30:0] code_b;

  tb_cheshire_boot_seq u_dut_a (
    .clk_i(clk), .rst_ni(rst_a), .start_i(start_a), .soc_rst_no(soc_a),
    .boot_mode_o(boot_a), .cfg_flags_o(cfg_a), .preload_req_o(preq_a),
    .preload_done_i(pdone_a), .exit_valid_i(ev_a), .exit_addr_i(ea_a),
    .exit_data_i(ed_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .timeout_o(to_a), .exit_code_o(code_a)
  );

  tb_cheshire_boot_seq #(
    .CfgIdx(3), .ResetCycles(4), .TimeoutCycles(100), .BootMode(2'd1)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_b), .start_i(start_b), .soc_rst_no(soc_b),
    .boot_mode_o(boot_b), .cfg_flags_o(cfg_b), .preload_req_o(preq_b),
    .preload_done_i(pdone_b), .exit_valid_i(ev_b), .exit_addr_i(ea_b),
    .exit_data_i(ed_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .timeout_o(to_b), .exit_code_o(code_b)
  );

  int n_total = 0;
  int n_bad   = 0;
  res_t exp_a[$];
  res_t exp_b[$];
  int   ndone_a = 0, ndone_b = 0;
  logic done_a_prev = 1'b0, done_b_prev = 1'b0;
  logic preq_b_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Completion monitors: each rising done_o retires one expected result.
  always @(negedge clk) begin
    if (preq_b) preq_b_seen = 1'b1;
    if (done_a && !done_a_prev) begin
      ndone_a++;
      check_eq("sb_a_nonempty", 64'(exp_a.size() != 0), 64'd1);
      if (exp_a.size() != 0) check_eq("sb_a_result", 64'({pass_a, to_a, code_a}), 64'(exp_a.pop_front()));
    end
    if (done_b && !done_b_prev) begin
      ndone_b++;
      check_eq("sb_b_nonempty", 64'(exp_b.size() != 0), 64'd1);
      if (exp_b.size() != 0) check_eq("sb_b_result", 64'({pass_b, to_b, code_b}), 64'(exp_b.pop_front()));
    end
    done_a_prev = done_a;
    done_b_prev = done_b;
  end

  task automatic eoc_a(input logic [31:0] data);
    ev_a = 1'b1; ea_a = ExitAddr; ed_a = data;
    step(1);
    ev_a = 1'b0; ed_a = '0;
  endtask

  task automatic seq_a();
    check_eq("a_rst_soc", 64'(soc_a), 0);
    check_eq("a_rst_outs", 64'({preq_a, busy_a, done_a, pass_a, to_a}), 0);
    check_eq("a_rst_code", 64'(code_a), 0);
    check_eq("a_boot_mode", 64'(boot_a), 0);
    check_eq("a_cfg_flags", 64'(cfg_a), 0);
    #3 rst_a = 1'b1;
    step(3);
    start_a = 1'b1; step(1); start_a = 1'b0;
    check_eq("a_hold_start", 64'({soc_a, busy_a}), 64'b01);
    step(3);
    start_a = 1'b1; pdone_a = 1'b1; step(1); start_a = 1'b0; pdone_a = 1'b0;
    step(11);
    check_eq("a_hold_last", 64'(soc_a), 0);
    step(1);
    check_eq("a_preload_entry", 64'({soc_a, preq_a, busy_a}), 64'b111);
    step(5);
    check_eq("a_preload_held", 64'(preq_a), 1);
    pdone_a = 1'b1; step(1); pdone_a = 1'b0;
    check_eq("a_run_entry", 64'({soc_a, preq_a, busy_a}), 64'b101);
    eoc_a(32'h6);
    check_eq("a_bit0_clear_ignored", 64'({done_a, busy_a}), 64'b01);
    ev_a = 1'b1; ea_a = 32'h0300_000C; ed_a = 32'h1; step(1); ev_a = 1'b0;
    check_eq("a_wrong_addr_ignored", 64'({done_a, busy_a}), 64'b01);
    exp_a.push_back('{pass: 1'b1, timeout: 1'b0, code: 31'd0});
    eoc_a(32'h1);
    check_eq("a_pass_flags", 64'({done_a, busy_a, pass_a, to_a}), 64'b1010);
    step(5);
    check_eq("a_done_sticky", 64'({done_a, soc_a}), 64'b11);
    start_a = 1'b1; step(1); start_a = 1'b0;
    check_eq("a_restart_clears", 64'({done_a, pass_a, busy_a}), 64'b001);
    step(16);
    pdone_a = 1'b1; step(1); pdone_a = 1'b0;
    exp_a.push_back('{pass: 1'b0, timeout: 1'b0, code: 31'd3});
    eoc_a(32'h7);
    check_eq("a_fail_code", 64'({pass_a, code_a}), 64'({1'b0, 31'd3}));
    start_a = 1'b1; step(1); start_a = 1'b0;
    step(16);
    pdone_a = 1'b1; step(1); pdone_a = 1'b0;
    step(3);
    #1 rst_a = 1'b0;
    #1;
    check_eq("a_async_rst", 64'({soc_a, preq_a, busy_a, done_a, pass_a, to_a}), 0);
    #2 rst_a = 1'b1;
    step(2);
    check_eq("a_idle_after_rst", 64'({soc_a, busy_a}), 0);
  endtask

  task automatic seq_b();
    check_eq("b_boot_mode", 64'(boot_b), 1);
    check_eq("b_cfg_flags", 64'(cfg_b), 64'b100);
    #3 rst_b = 1'b1;
    step(2);
    exp_b.push_back('{pass: 1'b0, timeout: 1'b1, code: 31'd0});
    start_b = 1'b1; step(1); start_b = 1'b0;
    check_eq("b_hold", 64'(soc_b), 0);
    step(4);
    check_eq("b_run_no_preload", 64'({soc_b, preq_b, busy_b}), 64'b101);
    pdone_b = 1'b1; step(1); pdone_b = 1'b0;
    step(98);
    check_eq("b_before_timeout", 64'({done_b, busy_b}), 64'b01);
    step(1);
    check_eq("b_timeout", 64'({done_b, to_b, pass_b}), 64'b110);
    start_b = 1'b1; step(1); start_b = 1'b0;
    step(4);
    step(99);
    exp_b.push_back('{pass: 1'b1, timeout: 1'b0, code: 31'd0});
    ev_b = 1'b1; ea_b = ExitAddr; ed_b = 32'h1;
    step(1);
    ev_b = 1'b0; ed_b = '0;
    check_eq("b_eoc_beats_timeout", 64'({done_b, to_b, pass_b}), 64'b101);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    fork
      seq_a();
      seq_b();
    join
    step(2);
    check_eq("a_sb_drained", 64'(exp_a.size()), 0);
    check_eq("b_sb_drained", 64'(exp_b.size()), 0);
    check_eq("a_done_count", 64'(ndone_a), 2);
    check_eq("b_done_count", 64'(ndone_b), 2);
    check_eq("b_preload_never", 64'(preq_b_seen), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
